btn_cond: RTL and testbench
===========================

Name: btn_cond

Overview:
- Input conditioner for the step-sequencer front panel.
- Synchronises and debounces the raw Tang Nano pushbuttons and mode switch.
- Delivers clean single-cycle command pulses (cursor move with auto-repeat, cell set, cell clear) plus a debounced edit/play mode level to the sequencer core.
- Sits directly upstream of the sequencer; all outputs are in the clk domain.

Parameters:
DEB_CYCLES, 270000, consecutive cycles a synchronised input must differ from its stable value before the change is accepted (10 ms at 27 MHz)
REP_DELAY, 13500000, cycles from the first move pulse to the first auto-repeat pulse (500 ms)
REP_PERIOD, 2700000, cycles between subsequent auto-repeat pulses (100 ms)

Ports:
clk  in  1  system clock, 27 MHz
rst  in  1  asynchronous active-low reset
btn  in  4  raw direction buttons, active low; btn[3]=x+1, btn[2]=y-1, btn[1]=y+1, btn[0]=x-1
btn3  in  1  raw mode switch; 1=edit, 0=play
Abtn  in  1  raw set button, active low
Bbtn  in  1  raw clear button, active low
mode_edit  out  1  debounced btn3 level
x_inc  out  1  one-cycle move pulse, x+1
x_dec  out  1  one-cycle move pulse, x-1
y_inc  out  1  one-cycle move pulse, y+1
y_dec  out  1  one-cycle move pulse, y-1
set_cell  out  1  one-cycle set pulse
clr_cell  out  1  one-cycle clear pulse

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-low. rst=0 forces all state to reset values immediately, independent of clk.
- Reset values:
  - sync and stable registers for btn, Abtn and Bbtn = 1 (released).
  - btn3 sync/stable = 0, so mode_edit = 0.
  - All pulse outputs = 0.
  - All counters = 0.
  - Repeat FSM = IDLE.
- Synchroniser: 2 flops per input (7 inputs).
- Debounce, per input, independently:
  - Counter increments while the synchronised value differs from the stable value.
  - Counter clears to 0 whenever the two are equal.
  - When the counter equals DEB_CYCLES-1 and the values still differ, the stable value takes the synchronised value and the counter clears.
  - A glitch shorter than DEB_CYCLES synchronised cycles never changes the stable value.
  - Counter width is clog2(DEB_CYCLES)+1.
- Latency: a raw change sampled at edge N updates the stable value at edge N+1+DEB_CYCLES. The corresponding pulse is registered on that same edge and is high for exactly the following cycle.
- Press is the stable value going 1->0. Release generates nothing.
- Edit gating: all pulse outputs are 0 while mode_edit=0. The repeat FSM is held in IDLE while mode_edit=0.
- Set/clear pulses:
  - set_cell pulses on an Abtn press only if stable Bbtn=1.
  - clr_cell pulses on a Bbtn press.
  - Simultaneous presses produce clr_cell only, so clear wins.
- Direction set: dir = the 4-bit stable direction vector. It is "single" when exactly one bit is 0.
- Repeat FSM states: IDLE, WAIT, RPT. Counter rc has width clog2(max(REP_DELAY,REP_PERIOD))+1.
- IDLE:
  - When dir becomes single: emit the pulse for that direction, rc=0, go to WAIT.
- WAIT:
  - rc increments each cycle.
  - When rc = REP_DELAY-1: emit pulse, rc=0, go to RPT.
- RPT:
  - rc increments each cycle.
  - When rc = REP_PERIOD-1: emit pulse, rc=0.
- In any state, a change of dir away from its value at entry (release, or a second button added) goes to IDLE with no pulse that cycle.
- If the new dir is itself single, IDLE handles it as a fresh press on the next stable change only. A second button released back to a single button is not a new press until that button's stable value changes again.
- Pulse timing: first move pulse at cycle t0, then t0+REP_DELAY, then t0+REP_DELAY+k*REP_PERIOD for k>=1.
- At most one direction pulse is high in any cycle. Direction pulses are independent of set/clear pulses.
- A mode_edit 1->0 mid-repeat goes to IDLE immediately; any pulse in that cycle is suppressed.
- Reset asserted mid-debounce or mid-repeat discards all progress.

Test Plan:
All scenarios use DEB_CYCLES=4, REP_DELAY=20, REP_PERIOD=8 and btn3 held at 1 beyond debounce unless stated.
- Reset: rst=0 with arbitrary inputs -> mode_edit=0, all pulses 0. Release rst with all buttons high -> no pulse for 100 cycles.
- Debounce: Abtn low for 3 synchronised cycles then high -> no set_cell. Abtn low held -> exactly one set_cell pulse, 1 cycle wide, 5 cycles after first sample. No pulse on release.
- Auto-repeat: btn=4'b0111 held 60 cycles after acceptance -> x_inc at t0, t0+20, t0+28, t0+36, t0+44, t0+52. No other pulses.
- Multi-press: hold btn[1] low, then add btn[0] low at t0+10 -> y_inc at t0 only. No x_dec and no further y_inc while both are held.
- Set/clear collision: Abtn and Bbtn fall together -> clr_cell only, set_cell stays 0.
- Mode gating: btn3=0 debounced, press btn[2] and Abtn -> no pulses. Switch btn3 to 1 mid-repeat and back to 0 -> pulses stop within 1 cycle of mode_edit falling.

Source files
------------

// File: rtl/btn_cond.sv
// -----------------------------------------------------------------------------
// btn_cond -- front-panel input conditioner for the step sequencer.
//
// Each raw panel input is synchronised (two flops), debounced independently,
// and turned into clean clk-domain commands for the sequencer core:
//   * a debounced edit/play mode level (mode_edit)
//   * one-cycle cursor move pulses with auto-repeat while a single
//     direction button is held
//   * one-cycle set / clear cell pulses (clear wins over set)
// All command pulses are suppressed while the panel is in play mode.
//
// Ports
//   clk       in   system clock (27 MHz)
//   rst       in   asynchronous reset, active low
//   btn[3:0]  in   raw direction buttons, active low
//                  btn[3]=x+1, btn[2]=y-1, btn[1]=y+1, btn[0]=x-1
//   btn3      in   raw mode switch, 1=edit, 0=play
//   Abtn      in   raw set button, active low
//   Bbtn      in   raw clear button, active low
//   mode_edit out  debounced btn3 level
//   x_inc     out  one-cycle move pulse, x+1
//   x_dec     out  one-cycle move pulse, x-1
//   y_inc     out  one-cycle move pulse, y+1
//   y_dec     out  one-cycle move pulse, y-1
//   set_cell  out  one-cycle set pulse
//   clr_cell  out  one-cycle clear pulse
// -----------------------------------------------------------------------------
module btn_cond #(
    parameter int DEB_CYCLES = 270000,
    parameter int REP_DELAY  = 13500000,
    parameter int REP_PERIOD = 2700000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic       btn3,
    input  logic       Abtn,
    input  logic       Bbtn,
    output logic       mode_edit,
    output logic       x_inc,
    output logic       x_dec,
    output logic       y_inc,
    output logic       y_dec,
    output logic       set_cell,
    output logic       clr_cell
);

    // Bit layout of the packed input vector:
    //   [3:0] direction buttons, [4] Abtn, [5] Bbtn, [6] btn3
    localparam int NIN  = 7;
    localparam int IA   = 4;
    localparam int IB   = 5;
    localparam int IM   = 6;
    localparam int DCW  = $clog2(DEB_CYCLES) + 1;
    localparam int RMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int RCW  = $clog2(RMAX) + 1;

    // Buttons idle high (released); the mode switch idles in play (0).
    localparam logic [NIN-1:0] RST_VAL  = 7'b0111111;
    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 1);
    localparam logic [RCW-1:0] DLY_LAST = RCW'(REP_DELAY - 1);
    localparam logic [RCW-1:0] PER_LAST = RCW'(REP_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RPT  = 2'd2
    } rep_state_t;

    // A direction vector is "single" when exactly one button is held.
    function automatic logic is_single(input logic [3:0] d);
        logic s;
        case (d)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: s = 1'b1;
            default:                            s = 1'b0;
        endcase
        return s;
    endfunction

    logic [NIN-1:0]           raw;
    logic [NIN-1:0]           sync_p0;
    logic [NIN-1:0]           sync_p1;
    logic [NIN-1:0]           stab;
    logic [NIN-1:0]           stab_nxt;
    logic [NIN-1:0][DCW-1:0]  deb_cnt;
    logic [NIN-1:0][DCW-1:0]  deb_cnt_nxt;

    rep_state_t               state;
    rep_state_t               state_nxt;
    logic [RCW-1:0]           rc;
    logic [RCW-1:0]           rc_nxt;

    logic [3:0]               dir;
    logic [3:0]               dir_nxt;
    logic                     dir_chg;
    logic                     fresh_press;
    logic                     mode_nxt;
    logic                     a_press;
    logic                     b_press;
    logic [3:0]               mv_nxt;
    logic                     set_nxt;
    logic                     clr_nxt;

    assign raw = {btn3, Bbtn, Abtn, btn};

    // ---- stage p0/p1: two-flop synchroniser -------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= RST_VAL;
            sync_p1 <= RST_VAL;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // ---- debounce: count consecutive disagreeing cycles per input ---------
    always_comb begin
        stab_nxt    = stab;
        deb_cnt_nxt = '0;
        for (int i = 0; i < NIN; i++) begin
            if (sync_p1[i] != stab[i]) begin
                if (deb_cnt[i] == DEB_LAST) begin
                    stab_nxt[i] = sync_p1[i];
                end else begin
                    deb_cnt_nxt[i] = deb_cnt[i] + DCW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stab    <= RST_VAL;
            deb_cnt <= '0;
        end else begin
            stab    <= stab_nxt;
            deb_cnt <= deb_cnt_nxt;
        end
    end

    assign mode_edit = stab[IM];

    // Events are derived from the value the stable register is about to take,
    // so each command pulse is registered on the same edge as the stable
    // change and gating follows the mode level of the pulse's own cycle.
    assign mode_nxt = stab_nxt[IM];
    assign dir      = stab[3:0];
    assign dir_nxt  = stab_nxt[3:0];
    assign dir_chg  = (dir_nxt != dir);
    assign a_press  = stab[IA] & ~stab_nxt[IA];
    assign b_press  = stab[IB] & ~stab_nxt[IB];

    // A new single direction only counts as a press when its own button just
    // went down; dropping back from two buttons to one is not a press.
    assign fresh_press = is_single(dir_nxt) & (|(dir & ~dir_nxt));

    // Clear wins: set requires the clear button to be (and stay) released.
    assign set_nxt = mode_nxt & a_press & stab_nxt[IB];
    assign clr_nxt = mode_nxt & b_press;

    // ---- auto-repeat FSM ---------------------------------------------------
    always_comb begin
        state_nxt = state;
        rc_nxt    = rc;
        mv_nxt    = '0;
        if (!mode_nxt) begin
            state_nxt = S_IDLE;
            rc_nxt    = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dir_chg && fresh_press) begin
                        mv_nxt    = ~dir_nxt;
                        rc_nxt    = '0;
                        state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dir_chg) begin
                        state_nxt = S_IDLE;
                        rc_nxt    = '0;
                    end else if (rc == DLY_LAST) begin
                        mv_nxt    = ~dir;
                        rc_nxt    = '0;
                        state_nxt = S_RPT;
                    end else begin
                        rc_nxt = rc + RCW'(1);
                    end
                end
                S_RPT: begin
                    if (dir_chg) begin
                        state_nxt = S_IDLE;
                        rc_nxt    = '0;
                    end else if (rc == PER_LAST) begin
                        mv_nxt = ~dir;
                        rc_nxt = '0;
                    end else begin
                        rc_nxt = rc + RCW'(1);
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    rc_nxt    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            rc    <= '0;
        end else begin
            state <= state_nxt;
            rc    <= rc_nxt;
        end
    end

    // ---- output registers --------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_inc    <= 1'b0;
            y_dec    <= 1'b0;
            y_inc    <= 1'b0;
            x_dec    <= 1'b0;
            set_cell <= 1'b0;
            clr_cell <= 1'b0;
        end else begin
            x_inc    <= mv_nxt[3];
            y_dec    <= mv_nxt[2];
            y_inc    <= mv_nxt[1];
            x_dec    <= mv_nxt[0];
            set_cell <= set_nxt;
            clr_cell <= clr_nxt;
        end
    end

endmodule

// File: tb/tb_btn_cond.sv
// -----------------------------------------------------------------------------
// tb_btn_cond -- self-checking bench for btn_cond (DEB=4, REP_DELAY=20,
// REP_PERIOD=8). A reference model built from sample-window debouncing and
// press-timestamp arithmetic predicts every output each cycle; directed
// scenarios add targeted count/timing checks, followed by random segments.
// -----------------------------------------------------------------------------
module tb_btn_cond;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;
    localparam logic [6:0] RST_VAL = 7'b0111111;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic       btn3, Abtn, Bbtn;
    logic       mode_edit, x_inc, x_dec, y_inc, y_dec, set_cell, clr_cell;
    logic [6:0] obs;

    always #5 clk = ~clk;

    btn_cond #(.DEB_CYCLES(DEB), .REP_DELAY(RD), .REP_PERIOD(RP)) dut (
        .clk(clk), .rst(rst), .btn(btn), .btn3(btn3), .Abtn(Abtn), .Bbtn(Bbtn),
        .mode_edit(mode_edit), .x_inc(x_inc), .x_dec(x_dec), .y_inc(y_inc),
        .y_dec(y_dec), .set_cell(set_cell), .clr_cell(clr_cell)
    );

    assign obs = {mode_edit, x_inc, x_dec, y_inc, y_dec, set_cell, clr_cell};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0] m_hist[$];
    logic [6:0] m_stab;
    bit         m_act;
    int         m_start;
    logic [3:0] m_mv;
    logic       m_set, m_clr;
    int         cyc = 0;

    function automatic bit single(input logic [3:0] d);
        int z = 0;
        for (int i = 0; i < 4; i++) if (!d[i]) z++;
        return z == 1;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < DEB + 2; i++) m_hist.push_back(RST_VAL);
        m_stab = RST_VAL; m_act = 0; m_start = 0; m_mv = '0; m_set = 0; m_clr = 0;
    endtask

    // An input's stable value flips once the DEB most recent synchronised
    // samples (raw delayed by two edges) all disagree with it.
    task automatic model_edge(input logic [6:0] r);
        logic [6:0] ns, smp;
        logic [3:0] od, nd;
        int sz, d;
        bit all_diff;
        ns = m_stab;
        sz = m_hist.size();
        for (int i = 0; i < 7; i++) begin
            all_diff = 1;
            for (int k = 2; k <= DEB + 1; k++) begin
                smp = m_hist[sz - k];
                if (smp[i] == m_stab[i]) all_diff = 0;
            end
            if (all_diff) ns[i] = ~m_stab[i];
        end
        m_hist.push_back(r);
        void'(m_hist.pop_front());
        od = m_stab[3:0];
        nd = ns[3:0];
        m_mv = '0; m_set = 0; m_clr = 0;
        if (ns[6]) begin
            m_clr = m_stab[5] & ~ns[5];
            m_set = m_stab[4] & ~ns[4] & ns[5];
            if (nd != od) begin
                if (m_act) m_act = 0;
                else if (single(nd) && ((od & ~nd) != 4'b0000)) begin
                    m_act = 1; m_start = cyc; m_mv = ~nd;
                end
            end else if (m_act) begin
                d = cyc - m_start;
                if (d == RD || (d > RD && (d - RD) % RP == 0)) m_mv = ~nd;
            end
        end else begin
            m_act = 0;
        end
        m_stab = ns;
    endtask

    // ---------------- observation counters ----------------
    int n_xi, n_xd, n_yi, n_yd, n_set, n_clr, n_late, set_at, fall_at;
    int xi_q[$];
    logic mode_prev = 1'b0;

    task automatic clear_counts();
        n_xi = 0; n_xd = 0; n_yi = 0; n_yd = 0; n_set = 0; n_clr = 0;
        n_late = 0; set_at = -1; fall_at = -1;
        xi_q.delete();
    endtask

    task automatic step();
        logic [6:0] want;
        @(posedge clk);
        cyc++;
        if (!rst) model_reset();
        else      model_edge({btn3, Bbtn, Abtn, btn});
        @(negedge clk);
        want = {m_stab[6], m_mv[3], m_mv[0], m_mv[1], m_mv[2], m_set, m_clr};
        chk($sformatf("out@%0d", cyc), {25'd0, obs}, {25'd0, want});
        if (x_inc) begin n_xi++; xi_q.push_back(cyc); end
        if (x_dec) n_xd++;
        if (y_inc) n_yi++;
        if (y_dec) n_yd++;
        if (set_cell) begin n_set++; set_at = cyc; end
        if (clr_cell) n_clr++;
        if (mode_prev && !mode_edit) fall_at = cyc;
        if (fall_at >= 0 && (x_inc || x_dec || y_inc || y_dec)) n_late++;
        mode_prev = mode_edit;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic int total_pulses();
        return n_xi + n_xd + n_yi + n_yd + n_set + n_clr;
    endfunction

    // ---------------- stimulus ----------------
    int c0, len, kind, j;
    int offs[6] = '{0, 20, 28, 36, 44, 52};
    logic [3:0] one = 4'b0001;
    logic [6:0] v, sv;

    initial begin
        rst = 1'b0;
        btn = 4'($urandom); btn3 = 1'($urandom); Abtn = 1'($urandom); Bbtn = 1'($urandom);
        model_reset();
        clear_counts();

        // Reset held with arbitrary inputs: everything idle.
        for (int i = 0; i < 6; i++) begin
            step();
            btn = 4'($urandom); btn3 = 1'($urandom); Abtn = 1'($urandom); Bbtn = 1'($urandom);
        end
        btn = 4'hF; Abtn = 1; Bbtn = 1; btn3 = 1;
        rst = 1'b1;
        clear_counts();
        idle(100);
        chk("rst_quiet", total_pulses(), 0);
        chk("mode_on", {31'd0, mode_edit}, 1);

        // Short Abtn glitch is filtered.
        clear_counts();
        Abtn = 0; idle(3); Abtn = 1; idle(12);
        chk("deb_glitch", n_set, 0);

        // Held Abtn: one pulse, 5 cycles after first sample, nothing on release.
        clear_counts();
        c0 = cyc + 1;
        Abtn = 0; idle(12);
        chk("set_count", n_set, 1);
        chk("set_lat", set_at, c0 + 5);
        clear_counts();
        Abtn = 1; idle(12);
        chk("set_release", total_pulses(), 0);

        // Auto-repeat on x+1.
        clear_counts();
        c0 = cyc + 1;
        btn = 4'b0111; idle(59);
        btn = 4'hF; idle(12);
        chk("rpt_count", xi_q.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < xi_q.size()) chk($sformatf("rpt_t%0d", i), xi_q[i], c0 + 5 + offs[i]);
        chk("rpt_other", n_xd + n_yi + n_yd + n_set + n_clr, 0);

        // Multi-press: second button kills repeat; dropping back is no press.
        clear_counts();
        c0 = cyc + 1;
        btn = 4'b1101; idle(10);
        btn = 4'b1100; idle(40);
        chk("multi_yinc", n_yi, 1);
        chk("multi_xdec", n_xd, 0);
        btn = 4'b1101; idle(30);
        chk("multi_back", n_yi, 1);
        btn = 4'hF; idle(12);

        // Set/clear collision: clear wins.
        clear_counts();
        Abtn = 0; Bbtn = 0; idle(12);
        chk("coll_clr", n_clr, 1);
        chk("coll_set", n_set, 0);
        Abtn = 1; Bbtn = 1; idle(12);

        // Play mode gates everything.
        btn3 = 0; idle(10);
        chk("mode_off", {31'd0, mode_edit}, 0);
        clear_counts();
        btn = 4'b1011; Abtn = 0; idle(40);
        chk("gate_off", total_pulses(), 0);
        btn = 4'hF; Abtn = 1; idle(10);
        btn3 = 1; idle(10);
        chk("mode_back", {31'd0, mode_edit}, 1);
        clear_counts();
        c0 = cyc + 1;
        btn = 4'b1011; idle(36);
        btn3 = 0; idle(30);
        chk("gate_fall", fall_at, c0 + 41);
        chk("gate_early", n_yd, 3);
        chk("gate_late", n_late, 0);
        btn = 4'hF; btn3 = 1; idle(15);

        // Asynchronous reset mid-repeat with the button still held.
        btn = 4'b1110; idle(27);
        #2 rst = 1'b0;
        #1 chk("async_rst", {25'd0, obs}, 0);
        @(negedge clk);
        idle(3);
        rst = 1'b1;
        idle(40);
        btn = 4'hF; idle(12);

        // Random segments with occasional one-cycle glitches.
        for (int s = 0; s < 150; s++) begin
            len  = $urandom_range(1, 60);
            kind = $urandom_range(0, 3);
            case (kind)
                0:       btn = 4'hF;
                1, 2:    btn = ~(one << $urandom_range(0, 3));
                default: btn = 4'($urandom);
            endcase
            Abtn = ($urandom_range(0, 2) != 0);
            Bbtn = ($urandom_range(0, 2) != 0);
            btn3 = ($urandom_range(0, 7) != 0);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 9) == 0) begin
                    sv = {btn3, Bbtn, Abtn, btn};
                    v  = sv;
                    j  = $urandom_range(0, 6);
                    v[j] = ~v[j];
                    {btn3, Bbtn, Abtn, btn} = v;
                    step();
                    {btn3, Bbtn, Abtn, btn} = sv;
                end else begin
                    step();
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
